// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
// SWEEP_GOLDEN_EN enables the optional golden-table check in the top.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  // Reference truth table for a 3-input NAND, indexed by vector (bit 0 = vector 000).
  localparam logic [7:0] GOLDEN_NAND3 = 8'b0111_1111;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

  // A HOLD of 1 still needs a one-bit counter.
  function automatic int cnt_width(input int hold);
    return (hold <= 1) ? 1 : clog2(hold);
  endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// Hold counter for the sweeper: counts 0..HOLD-1 while enabled and pulses tc
// on the last cycle of each hold, then wraps to zero.
module sweep_hold_timer
  import sweep_pkg::*;
#(
  parameter int HOLD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = cnt_width(HOLD);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HOLD - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = en && (cnt == TC_VAL);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus generator and response checker for a pair of small combinational DUTs.
// Define SWEEP_GOLDEN_EN to also compare y_a against the GOLDEN truth table.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int HOLD = 10
`ifdef SWEEP_GOLDEN_EN
  ,
  parameter logic [2**N_IN-1:0] GOLDEN = GOLDEN_NAND3
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec,
  input  logic            y_a,
  input  logic            y_b,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   mismatch_cnt,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
);

  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

  sweep_state_t state;
  logic         sample;
  logic         launch;
  logic         fail;

  assign launch = start && (state != DRIVE);

`ifdef SWEEP_GOLDEN_EN
  assign fail = (y_a != y_b) || (y_a != GOLDEN[vec]);
`else
  assign fail = (y_a != y_b);
`endif

  sweep_hold_timer #(.HOLD(HOLD)) u_hold_timer (
    .clk (clk),
    .rst (rst),
    .clr (launch),
    .en  (state == DRIVE),
    .tc  (sample)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      vec          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mismatch_cnt <= '0;
      fail_valid   <= 1'b0;
      fail_vec     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= DRIVE;
            vec          <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            mismatch_cnt <= '0;
            fail_valid   <= 1'b0;
            fail_vec     <= '0;
          end
        end
        DRIVE: begin
          if (sample) begin
            if (fail) begin
              mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                fail_vec   <= vec;
              end
            end
            // vec stays on the last vector once the sweep completes
            if (vec == LAST_VEC) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              vec <= vec + N_IN'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench for truth_table_sweeper (N_IN=3, HOLD=4).
module tb_truth_table_sweeper;

  localparam int N_IN = 3;
  localparam int HOLD = 4;
  localparam int NV   = 1 << N_IN;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [N_IN-1:0] vec;
  logic            y_a;
  logic            y_b;
  logic            busy;
  logic            done;
  logic [N_IN:0]   mismatch_cnt;
  logic            fail_valid;
  logic [N_IN-1:0] fail_vec;

  logic [NV-1:0] tab_a;
  logic [NV-1:0] tab_b;

  int n_checks = 0;
  int n_errors = 0;

  truth_table_sweeper #(.N_IN(N_IN), .HOLD(HOLD)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .vec          (vec),
    .y_a          (y_a),
    .y_b          (y_b),
    .busy         (busy),
    .done         (done),
    .mismatch_cnt (mismatch_cnt),
    .fail_valid   (fail_valid),
    .fail_vec     (fail_vec)
  );

  // The two "implementations" are plain truth tables looked up by vec.
  assign y_a = tab_a[vec];
  assign y_b = tab_b[vec];

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_vec"},   int'(vec), 0);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_done"},  int'(done), 0);
    check({tag, "_cnt"},   int'(mismatch_cnt), 0);
    check({tag, "_fv"},    int'(fail_valid), 0);
    check({tag, "_fvec"},  int'(fail_vec), 0);
  endtask

  // Runs one sweep from IDLE or DONE. drive_start_at pulses start during DRIVE
  // at that cycle; rst_at asserts rst (with start held high) at that cycle.
  task automatic run_sweep(input logic [NV-1:0] a_t, input logic [NV-1:0] b_t,
                           input int drive_start_at, input int rst_at);
    logic [NV-1:0] fmask;
    int exp_cnt;
    int exp_first;
    int partial;
    tab_a = a_t;
    tab_b = b_t;
    fmask = a_t ^ b_t;
`ifdef SWEEP_GOLDEN_EN
    fmask = fmask | (a_t ^ 8'b0111_1111);
`endif
    exp_cnt   = 0;
    exp_first = 0;
    for (int v = NV - 1; v >= 0; v--) begin
      if (fmask[v]) begin
        exp_cnt++;
        exp_first = v;
      end
    end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", int'(busy), 1);
    check("start_done", int'(done), 0);
    check("start_cnt", int'(mismatch_cnt), 0);
    check("start_fv", int'(fail_valid), 0);

    for (int i = 0; i < NV * HOLD; i++) begin
      if (i == rst_at) begin
        partial = 0;
        for (int v = 0; v < i / HOLD; v++) partial += int'(fmask[v]);
        check("pre_rst_cnt", int'(mismatch_cnt), partial);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check_reset_values("rst_mid");
        @(negedge clk);
        check("rst_start_ignored", int'(busy), 0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post_rst_idle", int'(busy), 0);
        return;
      end
      check("vec", int'(vec), i / HOLD);
      check("busy", int'(busy), 1);
      if (i == drive_start_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end

    check("end_busy", int'(busy), 0);
    check("end_done", int'(done), 1);
    check("end_vec", int'(vec), NV - 1);
    check("end_cnt", int'(mismatch_cnt), exp_cnt);
    check("end_fv", int'(fail_valid), int'(exp_cnt != 0));
    check("end_fvec", int'(fail_vec), exp_first);
    repeat (3) @(negedge clk);
    check("hold_done", int'(done), 1);
    check("hold_cnt", int'(mismatch_cnt), exp_cnt);
  endtask

  initial begin
    logic [NV-1:0] ra;
    logic [NV-1:0] rb;
    rst   = 1'b1;
    start = 1'b0;
    tab_a = 8'b0111_1111;
    tab_b = 8'b0111_1111;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // identical NAND3 pair, from IDLE
    run_sweep(8'b0111_1111, 8'b0111_1111, -1, -1);
    // start in DONE: y_b inverted only at vector 5
    run_sweep(8'b0111_1111, 8'b0101_1111, -1, -1);
    // y_b stuck at 0
    run_sweep(8'b0111_1111, 8'b0000_0000, -1, -1);
    // start pulsed during DRIVE must not disturb the sweep
    run_sweep(8'b0111_1111, 8'b0111_0111, 10, -1);
    // both implementations realised as NOR3
    run_sweep(8'b0000_0001, 8'b0000_0001, -1, -1);
    // reset at cycle 13 with early failures recorded
    run_sweep(8'b0111_1111, 8'b0111_1000, -1, 13);
    // fresh sweep from IDLE after the mid-run reset
    run_sweep(8'b0111_1111, 8'b1111_1111, -1, -1);

    for (int r = 0; r < 8; r++) begin
      ra = NV'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra : NV'($urandom);
      run_sweep(ra, rb, (r % 2 == 1) ? int'($urandom_range(0, NV * HOLD - 1)) : -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

- Self-running exhaustive stimulus generator and response checker for small combinational gate-level implementations, such as the 3-input NAND-only and NOR-only realisations.
- Drives every input vector in binary order, holds each one for a fixed number of cycles, and samples the two implementation outputs at the end of each hold.
- Counts disagreements and latches the first failing vector.
- Sits directly upstream (stimulus) and downstream (comparison) of the DUT pair, replacing hand-written per-vector stimulus.

## Interface
Parameters:
- N_IN, default 3: number of DUT inputs; sweeps 2^N_IN vectors; legal range 1..8.
- HOLD, default 10: cycles each vector is held; minimum 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  begin a sweep; sampled in IDLE or DONE only.
- vec  out  N_IN  current input vector; MSB drives A, LSB drives C.
- y_a  in  1  output of implementation A (NAND version).
- y_b  in  1  output of implementation B (NOR version).
- busy  out  1  high while vectors are being driven.
- done  out  1  high after a completed sweep, until the next start or rst.
- mismatch_cnt  out  N_IN+1  number of vectors that failed the check.
- fail_valid  out  1  at least one failure seen in this sweep.
- fail_vec  out  N_IN  first failing vector; valid only when fail_valid=1.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- Reset values: state=IDLE, vec=0, busy=0, done=0, mismatch_cnt=0, fail_valid=0, fail_vec=0, hold counter=0.
- IDLE -> DRIVE on start=1:
  - clear vec, hold counter, mismatch_cnt, fail_valid and fail_vec.
- DRIVE:
  - hold counter increments each cycle.
  - The sample point is the cycle where hold counter = HOLD-1. At the sample point:
    - Fail condition: y_a != y_b.
    - On fail: mismatch_cnt += 1. If fail_valid=0, then set fail_vec=vec and fail_valid=1.
    - If vec = 2^N_IN-1, go to DONE; otherwise vec += 1 and hold counter = 0.
- DONE:
  - done=1; vec holds the last vector; result outputs are frozen.
  - start=1 clears the results and re-enters DRIVE (same as from IDLE).
- start during DRIVE is ignored. A sweep cannot be restarted mid-run except by rst.
- rst mid-sweep: all outputs return to reset values on the next edge; rst has priority over start.
- mismatch_cnt width N_IN+1 holds up to 2^N_IN, so no saturation or wrap is possible.

## Timing
- Edge where start is sampled in IDLE: on that edge busy=1 and vec=0; vec=0 is visible the following cycle.
- Each vector is stable for exactly HOLD cycles. The DUT has a combinational path and is sampled on the final edge of the hold.
- mismatch_cnt and fail_* update on the edge ending the sample cycle.
- busy stays high for exactly 2^N_IN*HOLD cycles.
- On the edge after the last sample: done=1 and busy=0, in the same edge.
- HOLD=1: a new vector appears every cycle; no idle gap between vectors.

## Configuration
- SWEEP_GOLDEN_EN defined:
  - adds parameter GOLDEN (width 2^N_IN, default 8'b0111_1111, i.e. NAND3);
  - fail condition becomes (y_a != y_b) || (y_a != GOLDEN[vec]).
- Undefined: no GOLDEN parameter; only the cross-comparison y_a vs y_b is performed.

## Structure
- Package sweep_pkg contains:
  - the state enum (IDLE, DRIVE, DONE);
  - the hold-counter width function clog2(HOLD);
  - the default GOLDEN constant.
- One sub-module, sweep_hold_timer:
  - loadable counter with a clear input and a terminal-count pulse at HOLD-1;
  - instantiated once; its terminal-count pulse is the sample strobe.

## Test plan
- Identical DUTs, HOLD=4, N_IN=3, start pulse:
  - vec steps 0..7, each held 4 cycles;
  - busy=1 for exactly 32 cycles; done=1 on the next edge;
  - mismatch_cnt=0, fail_valid=0.
- y_b forced to invert y_a only when vec=5:
  - mismatch_cnt=1, fail_vec=3'b101, fail_valid=1.
- y_b stuck at 0, y_a=NAND3:
  - mismatch_cnt=7; fail_vec=0, since the first failing vector is 0.
- rst asserted at cycle 13 of a sweep:
  - the next edge shows all reset values;
  - start is ignored while rst=1.
- start pulsed in DRIVE:
  - the sweep continues unchanged.
- start pulsed in DONE:
  - results clear and a new 32-cycle sweep begins.
- SWEEP_GOLDEN_EN with GOLDEN=NAND3 and both DUTs wired as NOR3:
  - mismatch_cnt=6 (vectors 1..6 disagree with NAND3);
  - fail_vec=1.
